// File: rtl/ntt_ctrl.sv
// ntt_ctrl: sequences one butterfly per cycle through an in-place forward/inverse NTT.
// Define NTT_CTRL_PERF_CNT_EN to enable the saturating busy-cycle counter on cycles_o.
module ntt_ctrl #(
  parameter int unsigned N    = 256,
  parameter int unsigned LOGN = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic            sel_red_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            rd_en_o,
  output logic [LOGN-1:0] rd_addr_a_o,
  output logic [LOGN-1:0] rd_addr_b_o,
  output logic [LOGN-1:0] tw_addr_o,
  output logic            wr_en_o,
  output logic [LOGN-1:0] wr_addr_a_o,
  output logic [LOGN-1:0] wr_addr_b_o,
  output logic            sel_butterfly_o,
  output logic            sel_red_o,
  output logic [15:0]     cycles_o
);

  localparam int unsigned    LW   = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam logic [LOGN-1:0] HALF = LOGN'(N / 2);
  localparam logic [LW-1:0]   LTOP = LW'(LOGN - 1);
  localparam logic [LOGN:0]   KTOP = {1'b1, {LOGN{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   l_q, l_d;
  logic [LOGN-1:0] i_q, i_d;
  logic [LOGN:0]   k_q, k_d;
  logic            mode_q, mode_d, red_q, red_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            rd_en_q, rd_en_d;
  logic [LOGN-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d, tw_q, tw_d;
  logic            wr_en_q, wr_en_d;
  logic [LOGN-1:0] wr_a_q, wr_a_d, wr_b_q, wr_b_d;
  logic            sel_bf_q, sel_bf_d, sel_red_q, sel_red_d;

  logic            issue, iss_mode, last_layer;
  logic [LW-1:0]   iss_l;
  logic [LOGN-1:0] iss_i, len, off;
  logic [LOGN:0]   kbase;

`ifdef NTT_CTRL_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d;
`endif

  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    i_d      = i_q;
    k_d      = k_q;
    mode_d   = mode_q;
    red_d    = red_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_en_d  = 1'b0;
    rd_a_d   = rd_a_q;
    rd_b_d   = rd_b_q;
    tw_d     = tw_q;
    issue    = 1'b0;
    iss_l    = l_q;
    iss_i    = i_q;
    iss_mode = mode_q;
    kbase    = k_q;
    len      = '0;
    off      = '0;
    last_layer = mode_q ? (l_q == LTOP) : (l_q == LW'(red_q));

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          mode_d   = mode_i;
          red_d    = sel_red_i;
          busy_d   = 1'b1;
          iss_mode = mode_i;
          iss_l    = mode_i ? LW'(sel_red_i) : LTOP;
          iss_i    = '0;
          kbase    = mode_i ? (KTOP >> sel_red_i) : '0;
          issue    = 1'b1;
        end
      end
      RUN: begin
        if (i_q == HALF) state_d = DRAIN;
        else             issue   = 1'b1;
      end
      DRAIN: begin
        if (last_layer) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
          iss_l   = mode_q ? l_q + 1'b1 : l_q - 1'b1;
          iss_i   = '0;
          issue   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Twiddle index steps at the first butterfly of every group (off == 0).
    if (issue) begin
      len     = LOGN'(1) << iss_l;
      off     = iss_i & (len - LOGN'(1));
      rd_a_d  = (((iss_i >> iss_l) << iss_l) << 1) | off;
      rd_b_d  = rd_a_d + len;
      k_d     = (off == '0) ? (iss_mode ? kbase - 1'b1 : kbase + 1'b1) : kbase;
      tw_d    = k_d[LOGN-1:0];
      rd_en_d = 1'b1;
      l_d     = iss_l;
      i_d     = iss_i + 1'b1;
    end

    wr_en_d   = rd_en_q;
    wr_a_d    = rd_a_q;
    wr_b_d    = rd_b_q;
    sel_bf_d  = mode_q;
    sel_red_d = red_q;

`ifdef NTT_CTRL_PERF_CNT_EN
    cyc_d = cyc_q;
    if (state_q == IDLE && start_i) cyc_d = '0;
    else if (busy_q && cyc_q != '1) cyc_d = cyc_q + 1'b1;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      l_q       <= '0;
      i_q       <= '0;
      k_q       <= '0;
      mode_q    <= 1'b0;
      red_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
      tw_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_a_q    <= '0;
      wr_b_q    <= '0;
      sel_bf_q  <= 1'b0;
      sel_red_q <= 1'b0;
`ifdef NTT_CTRL_PERF_CNT_EN
      cyc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      l_q       <= l_d;
      i_q       <= i_d;
      k_q       <= k_d;
      mode_q    <= mode_d;
      red_q     <= red_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_a_q    <= rd_a_d;
      rd_b_q    <= rd_b_d;
      tw_q      <= tw_d;
      wr_en_q   <= wr_en_d;
      wr_a_q    <= wr_a_d;
      wr_b_q    <= wr_b_d;
      sel_bf_q  <= sel_bf_d;
      sel_red_q <= sel_red_d;
`ifdef NTT_CTRL_PERF_CNT_EN
      cyc_q     <= cyc_d;
`endif
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign rd_en_o         = rd_en_q;
  assign rd_addr_a_o     = rd_a_q;
  assign rd_addr_b_o     = rd_b_q;
  assign tw_addr_o       = tw_q;
  assign wr_en_o         = wr_en_q;
  assign wr_addr_a_o     = wr_a_q;
  assign wr_addr_b_o     = wr_b_q;
  assign sel_butterfly_o = sel_bf_q;
  assign sel_red_o       = sel_red_q;
`ifdef NTT_CTRL_PERF_CNT_EN
  assign cycles_o        = cyc_q;
`else
  assign cycles_o        = '0;
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: scoreboard bench; a loop-nest NTT/INTT schedule model feeds expected
// read/write/done events with their cycle numbers, a negedge monitor checks them.
module tb_ntt_ctrl;
  localparam int N    = 256;
  localparam int LOGN = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic            mode_i = 1'b0;
  logic            sel_red_i = 1'b0;
  logic            busy_o, done_o, rd_en_o, wr_en_o, sel_butterfly_o, sel_red_o;
  logic [LOGN-1:0] rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o;
  logic [15:0]     cycles_o;

  ntt_ctrl #(.N(N), .LOGN(LOGN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .sel_red_i(sel_red_i), .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
    .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o), .tw_addr_o(tw_addr_o),
    .wr_en_o(wr_en_o), .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o),
    .sel_butterfly_o(sel_butterfly_o), .sel_red_o(sel_red_o), .cycles_o(cycles_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int cyc; int a; int b; int t; } rd_t;
  typedef struct { int cyc; int a; int b; int bf; int red; } wr_t;
  typedef struct { int cyc; int cnt; } dn_t;

  rd_t rdq[$];
  wr_t wrq[$];
  dn_t dnq[$];
  int  cyc = 0;
  int  busy_lo = 0;
  int  busy_hi = 0;
  int  total = 0;
  int  bad = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Textbook loop nest: one group per twiddle, butterflies back to back, one bubble per layer.
  task automatic push_run(input int c0, input bit md, input bit rd, output int dn);
    int lmin, nl, k, c, l, len;
    rd_t r;
    wr_t w;
    dn_t d;
    lmin = rd ? 1 : 0;
    nl   = LOGN - lmin;
    k    = md ? (1 << nl) : 0;
    c    = c0 + 1;
    for (int m = 0; m < nl; m++) begin
      l   = md ? lmin + m : LOGN - 1 - m;
      len = 1 << l;
      for (int s = 0; s < N; s += 2 * len) begin
        k = md ? k - 1 : k + 1;
        for (int j = s; j < s + len; j++) begin
          r.cyc = c;     r.a = j; r.b = j + len; r.t = k;
          w.cyc = c + 1; w.a = j; w.b = j + len; w.bf = md; w.red = rd;
          rdq.push_back(r);
          wrq.push_back(w);
          c++;
        end
      end
      c++;
    end
    d.cyc = c;
`ifdef NTT_CTRL_PERF_CNT_EN
    d.cnt = nl * (N / 2 + 1);
`else
    d.cnt = 0;
`endif
    dnq.push_back(d);
    busy_lo = c0 + 1;
    busy_hi = c;
    dn = c;
  endtask

  always @(negedge clk_i) begin
    rd_t r;
    wr_t w;
    dn_t d;
    bit  eb;
    eb = (cyc >= busy_lo) && (cyc < busy_hi);
    total++;
    if (busy_o !== eb) begin
      bad++;
      $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy_o, eb);
    end
    if (rd_en_o !== 1'b0) begin
      total++;
      if (rdq.size() == 0) begin
        bad++;
        $display("FAIL rd_extra cyc=%0d got rd_en=%0b with nothing expected", cyc, rd_en_o);
      end else begin
        r = rdq.pop_front();
        if (r.cyc != cyc || int'(rd_addr_a_o) != r.a || int'(rd_addr_b_o) != r.b ||
            int'(tw_addr_o) != r.t) begin
          bad++;
          $display("FAIL rd_beat got cyc=%0d a=%0d b=%0d tw=%0d exp cyc=%0d a=%0d b=%0d tw=%0d",
                   cyc, rd_addr_a_o, rd_addr_b_o, tw_addr_o, r.cyc, r.a, r.b, r.t);
        end
      end
    end
    if (wr_en_o !== 1'b0) begin
      total++;
      if (wrq.size() == 0) begin
        bad++;
        $display("FAIL wr_extra cyc=%0d got wr_en=%0b with nothing expected", cyc, wr_en_o);
      end else begin
        w = wrq.pop_front();
        if (w.cyc != cyc || int'(wr_addr_a_o) != w.a || int'(wr_addr_b_o) != w.b ||
            int'(sel_butterfly_o) != w.bf || int'(sel_red_o) != w.red) begin
          bad++;
          $display("FAIL wr_beat got cyc=%0d a=%0d b=%0d bf=%0d red=%0d exp cyc=%0d a=%0d b=%0d bf=%0d red=%0d",
                   cyc, wr_addr_a_o, wr_addr_b_o, sel_butterfly_o, sel_red_o,
                   w.cyc, w.a, w.b, w.bf, w.red);
        end
      end
    end
    if (done_o !== 1'b0) begin
      total++;
      if (dnq.size() == 0) begin
        bad++;
        $display("FAIL done_extra cyc=%0d got done=%0b with nothing expected", cyc, done_o);
      end else begin
        d = dnq.pop_front();
        if (d.cyc != cyc || int'(cycles_o) != d.cnt) begin
          bad++;
          $display("FAIL done got cyc=%0d cycles=%0d exp cyc=%0d cycles=%0d",
                   cyc, cycles_o, d.cyc, d.cnt);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    total++;
    if ({busy_o, done_o, rd_en_o, wr_en_o, sel_butterfly_o, sel_red_o} !== 6'b0 ||
        rd_addr_a_o !== '0 || rd_addr_b_o !== '0 || tw_addr_o !== '0 ||
        wr_addr_a_o !== '0 || wr_addr_b_o !== '0 || cycles_o !== '0) begin
      bad++;
      $display("FAIL %s got busy=%0b done=%0b rd=%0b wr=%0b ra=%0d rb=%0d tw=%0d wa=%0d wb=%0d bf=%0b red=%0b cyc=%0d exp all 0",
               name, busy_o, done_o, rd_en_o, wr_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
               wr_addr_a_o, wr_addr_b_o, sel_butterfly_o, sel_red_o, cycles_o);
    end
  endtask

  task automatic issue_start(input bit md, input bit rd, input bit hold,
                             output int c0, output int dn);
    @(negedge clk_i);
    start_i   = 1'b1;
    mode_i    = md;
    sel_red_i = rd;
    c0        = cyc;
    push_run(c0, md, rd, dn);
    @(negedge clk_i);
    if (!hold) begin
      start_i   = 1'b0;
      mode_i    = ~md;
      sel_red_i = ~rd;
    end
  endtask

  task automatic wait_end(input int dn, input string name);
    while (cyc < dn + 1) @(negedge clk_i);
    total++;
    if (rdq.size() != 0 || wrq.size() != 0 || dnq.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover got rd=%0d wr=%0d done=%0d pending exp 0 0 0",
               name, rdq.size(), wrq.size(), dnq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d exp run to complete", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int c0, dn, dn2;
    bit md, rd;
    repeat (2) @(negedge clk_i);
    start_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_zero("reset_state");
    rst_ni  = 1'b1;
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // NTT q=3329 with a stray start pulse in the middle of the run.
    issue_start(1'b0, 1'b1, 1'b0, c0, dn);
    while (cyc < c0 + 300) @(negedge clk_i);
    start_i = 1'b1;
    mode_i  = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_end(dn, "ntt_3329");

    // INTT q=8380417 with start held through done, chaining into an NTT q=8380417.
    issue_start(1'b1, 1'b0, 1'b1, c0, dn);
    while (cyc < dn) @(negedge clk_i);
    mode_i    = 1'b0;
    sel_red_i = 1'b0;
    push_run(dn + 1, 1'b0, 1'b0, dn2);
    repeat (2) @(negedge clk_i);
    start_i   = 1'b0;
    mode_i    = 1'b1;
    sel_red_i = 1'b1;
    wait_end(dn2, "chained");

    // Reset in the middle of a run, then an identical fresh run.
    md = 1'($urandom_range(0, 1));
    rd = 1'($urandom_range(0, 1));
    issue_start(md, rd, 1'b0, c0, dn);
    while (cyc < c0 + 500) @(negedge clk_i);
    #2;
    rst_ni  = 1'b0;
    start_i = 1'b1;
    rdq.delete();
    wrq.delete();
    dnq.delete();
    busy_lo = 0;
    busy_hi = 0;
    #1;
    check_zero("reset_midrun");
    repeat (3) @(negedge clk_i);
    check_zero("reset_held");
    rst_ni  = 1'b1;
    start_i = 1'b0;
    @(negedge clk_i);
    issue_start(md, rd, 1'b0, c0, dn);
    wait_end(dn, "after_reset");

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk_i);
      issue_start(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, c0, dn);
      wait_end(dn, "random");
    end

    repeat (4) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer that drives one single-cycle butterfly unit through a complete in-place forward NTT or inverse NTT over an N-coefficient polynomial memory. It issues one butterfly per cycle: operand read addresses, twiddle ROM address, write-back addresses, and the butterfly/reduction selects. It sits between the top-level core FSM, which supplies start/mode and waits on done, and the coefficient RAM, twiddle ROM and butterfly datapath. Final n^-1 scaling of the INTT is outside this block.

## Interface
- N, default 256: polynomial length, power of two.
- LOGN, default 8: log2(N).
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- mode_i  in  1  0 = forward NTT (Cooley-Tukey), 1 = inverse NTT (Gentleman-Sande). Latched at start.
- sel_red_i  in  1  0 = q 8380417 (8 layers, down to len 1), 1 = q 3329 (7 layers, down to len 2). Latched at start.
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  one-cycle completion pulse.
- rd_en_o  out  1  coefficient RAM read strobe.
- rd_addr_a_o, rd_addr_b_o  out  LOGN  read addresses of the a and b operands.
- tw_addr_o  out  LOGN  twiddle ROM address, issued with rd_en_o.
- wr_en_o  out  1  write-back strobe for a'/b'.
- wr_addr_a_o, wr_addr_b_o  out  LOGN  write-back addresses.
- sel_butterfly_o  out  1  butterfly select, valid with wr_en_o.
- sel_red_o  out  1  reduction select, valid with wr_en_o.
- cycles_o  out  16  performance counter; see Configuration.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: when start_i=1, latch mode and sel_red, load the layer and k counters, go to RUN.
  - RUN: one butterfly issued per cycle; after the N/2-th butterfly of a layer, go to DRAIN.
  - DRAIN: single bubble cycle with rd_en_o=0. Go to RUN if layers remain, otherwise DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
- Layer index l (len = 2^l):
  - Lowest layer lmin = sel_red ? 1 : 0.
  - NTT runs l from LOGN-1 down to lmin. INTT runs l from lmin up to LOGN-1.
  - Layer count L = LOGN - lmin.
- Butterfly counter i runs 0..N/2-1 within each layer.
  - off = i & (len-1); grp = i >> l.
  - a = (grp << (l+1)) | off; b = a + len. All arithmetic is LOGN bits, with no wrap inside a layer.
- Twiddle index k changes once per group, i.e. whenever off = 0:
  - NTT: k resets to 0 at start and is pre-incremented, so the first twiddle is 1.
  - INTT: k resets to 2^L and is pre-decremented, so the first twiddle is 2^L - 1.
- Write-back stage: wr_en_o, wr_addr_a/b_o, sel_butterfly_o and sel_red_o are the read-stage values registered once. sel_butterfly_o equals the latched mode.
- A start_i arriving outside IDLE is ignored and never queued.
- Reset mid-run: state returns to IDLE and all outputs clear immediately. The in-flight write is dropped. The RAM contents are then undefined and the core must reload them.

## Timing
- Reset value of every output is 0.
- Coefficient RAM and twiddle ROM are synchronous with 1-cycle read latency. The butterfly is combinational, so write-back occurs exactly 1 cycle after the read is issued.
- Start sampled in cycle c0:
  - first rd_en_o in c0+1;
  - first wr_en_o in c0+2;
  - done_o in c0 + 1 + L*(N/2 + 1).
- With N=256: done_o at c0+904 for q=3329 and c0+1033 for q=8380417.
- DRAIN guarantees that the final write of layer l lands before the first read of layer l±1. The RAM must be write-then-read across cycles.
- busy_o falls in the cycle DONE is entered, i.e. coincident with done_o. A start held high is accepted in the cycle after done_o.

## Configuration
- NTT_CTRL_PERF_CNT_EN defined:
  - cycles_o counts busy cycles of the current run. It clears when start is accepted and holds its final value after done.
  - It saturates at 16'hFFFF.
- Not defined: cycles_o is tied to 0 and the counter logic is absent.

## Test plan
- Reset: assert rst_ni=0 mid-clock -> all outputs 0 immediately; start_i ignored while in reset.
- NTT, q=3329, N=256:
  - first read a=0, b=128, tw=1;
  - first read of the second layer a=0, b=64, tw=2;
  - last read a=253, b=255, tw=127;
  - done_o at c0+904.
- INTT, q=8380417:
  - first read a=0, b=1, tw=255, sel_butterfly_o=1 on the matching write;
  - last read a=127, b=255, tw=1;
  - done_o at c0+1033.
- Pipeline alignment: every wr_en_o cycle carries the wr_addr_a/b_o of the read one cycle earlier; rd_en_o=0 on exactly L DRAIN cycles.
- start_i pulsed at c0+300 during a run -> ignored. start_i held high through done_o -> new run with first read at done+2.
- rst_ni low at c0+500, then start -> outputs clear, wr_en_o=0 from reset onward, new run identical to a fresh run. With NTT_CTRL_PERF_CNT_EN defined, cycles_o = 903 after a q=3329 run.
